// File: rtl/frame_acc_md_if.sv
// Beat-in / frame-result-out handshake bundle for frame_acc_md.
interface frame_acc_md_if #(
    parameter int DSIZE = 8,
    parameter int CH    = 2,
    parameter int ASIZE = 10,
    parameter int CSIZE = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [CH*DSIZE-1:0]   in_data;
    logic [CH-1:0]         in_bit;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH*ASIZE-1:0]   out_data;
    logic [CSIZE-1:0]      out_cnt;
    logic                  out_ovf;

    modport master (
        output in_valid, in_data, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_ovf
    );
endinterface

// File: rtl/frame_acc_md.sv
// Per-channel frame accumulator: sums (data + carry bit) over each frame and
// queues the frame sums, beat count and overflow flag in a small output FIFO.
module frame_acc_md #(
    parameter int DSIZE = 8,
    parameter int CH    = 2,
    parameter int ASIZE = 10,
    parameter int CSIZE = 8,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic           clock,
    input  logic           rst_n,
    frame_acc_md_if.slave  bus
);
    localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CSIZE-1:0] CNT_MAX  = {CSIZE{1'b1}};
    localparam logic [ASIZE-1:0] ACC_MAX  = {ASIZE{1'b1}};

    logic [CH-1:0][ASIZE-1:0]       acc_q, acc_d, sum_s;
    logic [CH-1:0][ASIZE:0]         v_s, s_s;
    logic [CH-1:0]                  ch_ovf_s;
    logic [CSIZE-1:0]               cnt_q, cnt_d, cnt_inc_s;
    logic                           ovf_q, ovf_d, ovf_new_s;
    logic                           first_q, first_d;
    logic [DEPTH-1:0][CH*ASIZE-1:0] mem_data_q, mem_data_d;
    logic [DEPTH-1:0][CSIZE-1:0]    mem_cnt_q, mem_cnt_d;
    logic [DEPTH-1:0]               mem_ovf_q, mem_ovf_d;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                    count_q, count_d;
    logic                           in_ready_s, accept_s, pop_s, push_s;

    // Every beat needs a free slot, so a frame end can always be queued.
    assign in_ready_s    = (count_q < FULL_CNT);
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (count_q != {(PW+1){1'b0}});
    assign bus.out_data  = mem_data_q[rd_ptr_q];
    assign bus.out_cnt   = mem_cnt_q[rd_ptr_q];
    assign bus.out_ovf   = mem_ovf_q[rd_ptr_q];

    // Per-channel beat value added onto the running sum, with overflow handling.
    always_comb begin
        v_s      = '0;
        s_s      = '0;
        sum_s    = '0;
        ch_ovf_s = '0;
        for (int c = 0; c < CH; c++) begin
            v_s[c] = {{(ASIZE-DSIZE){1'b0}},
                      ({1'b0, bus.in_data[c*DSIZE +: DSIZE]} + {{DSIZE{1'b0}}, bus.in_bit[c]})};
            if (first_q) begin
                s_s[c] = v_s[c];
            end else begin
                s_s[c] = {1'b0, acc_q[c]} + v_s[c];
            end
            ch_ovf_s[c] = s_s[c][ASIZE];
            if (s_s[c][ASIZE] && (SAT != 0)) begin
                sum_s[c] = ACC_MAX;
            end else begin
                sum_s[c] = s_s[c][ASIZE-1:0];
            end
        end
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CSIZE'(1);
        end
        ovf_new_s = ovf_q | (|ch_ovf_s);
    end

    // Next-state for frame accumulation and FIFO bookkeeping.
    always_comb begin
        accept_s   = bus.in_valid & in_ready_s;
        pop_s      = bus.out_valid & bus.out_ready;
        push_s     = accept_s & bus.in_last;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        first_d    = first_q;
        mem_data_d = mem_data_q;
        mem_cnt_d  = mem_cnt_q;
        mem_ovf_d  = mem_ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (accept_s) begin
            if (bus.in_last) begin
                mem_data_d[wr_ptr_q] = sum_s;
                mem_cnt_d[wr_ptr_q]  = cnt_inc_s;
                mem_ovf_d[wr_ptr_q]  = ovf_new_s;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                acc_d                = '0;
                cnt_d                = '0;
                ovf_d                = 1'b0;
                first_d              = 1'b1;
            end else begin
                acc_d   = sum_s;
                cnt_d   = cnt_inc_s;
                ovf_d   = ovf_new_s;
                first_d = 1'b0;
            end
        end else begin
            first_d = first_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO and discards any partial frame.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            first_q    <= 1'b1;
            mem_data_q <= '0;
            mem_cnt_q  <= '0;
            mem_ovf_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            first_q    <= first_d;
            mem_data_q <= mem_data_d;
            mem_cnt_q  <= mem_cnt_d;
            mem_ovf_q  <= mem_ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_frame_acc_md.sv
// Bench for frame_acc_md: wrap and saturate instances share one stimulus
// stream and are scored against a frame-total reference model.
module tb_frame_acc_md;
    localparam int DSIZE = 8;
    localparam int CH    = 2;
    localparam int ASIZE = 10;
    localparam int CSIZE = 8;
    localparam int DEPTH = 4;
    localparam int AMOD  = 1 << ASIZE;
    localparam int CMAX  = (1 << CSIZE) - 1;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    frame_acc_md_if #(.DSIZE(DSIZE), .CH(CH), .ASIZE(ASIZE), .CSIZE(CSIZE)) bif0 ();
    frame_acc_md_if #(.DSIZE(DSIZE), .CH(CH), .ASIZE(ASIZE), .CSIZE(CSIZE)) bif1 ();

    assign bif1.in_valid  = bif0.in_valid;
    assign bif1.in_data   = bif0.in_data;
    assign bif1.in_bit    = bif0.in_bit;
    assign bif1.in_last   = bif0.in_last;
    assign bif1.out_ready = bif0.out_ready;

    frame_acc_md #(.DSIZE(DSIZE), .CH(CH), .ASIZE(ASIZE), .CSIZE(CSIZE), .DEPTH(DEPTH), .SAT(0))
        dut0 (.clock(clock), .rst_n(rst_n), .bus(bif0));
    frame_acc_md #(.DSIZE(DSIZE), .CH(CH), .ASIZE(ASIZE), .CSIZE(CSIZE), .DEPTH(DEPTH), .SAT(1))
        dut1 (.clock(clock), .rst_n(rst_n), .bus(bif1));

    typedef struct { int tot0; int tot1; int beats; } frame_t;
    typedef struct { int d0; int d1; int b0; int b1; int e0; int e1; } vec_t;

    frame_t              exp_q[$];
    frame_t              mon_e;
    int                  mon_sz;
    int                  fr_tot0 = 0, fr_tot1 = 0, fr_beats = 0;
    logic                held_v = 1'b0;
    logic [CH*ASIZE-1:0] held_d0, held_d1;
    logic [CSIZE-1:0]    held_c;
    logic                held_o0, held_o1;
    vec_t                tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int wrap_f(input int t); return t % AMOD; endfunction
    function automatic int sat_f(input int t); return (t >= AMOD) ? AMOD - 1 : t; endfunction

    task automatic cmp_head(input frame_t e);
        int ovf;
        ovf = ((e.tot0 >= AMOD) || (e.tot1 >= AMOD)) ? 1 : 0;
        check("wrap_ch0", bif0.out_data[ASIZE-1:0], wrap_f(e.tot0));
        check("wrap_ch1", bif0.out_data[2*ASIZE-1:ASIZE], wrap_f(e.tot1));
        check("wrap_cnt", bif0.out_cnt, (e.beats > CMAX) ? CMAX : e.beats);
        check("wrap_ovf", bif0.out_ovf, ovf);
        check("sat_ch0", bif1.out_data[ASIZE-1:0], sat_f(e.tot0));
        check("sat_ch1", bif1.out_data[2*ASIZE-1:ASIZE], sat_f(e.tot1));
        check("sat_cnt", bif1.out_cnt, (e.beats > CMAX) ? CMAX : e.beats);
        check("sat_ovf", bif1.out_ovf, ovf);
    endtask

    // Reference model: handshake outcome, frame totals and FIFO order at each negedge.
    always @(negedge clock) begin
        if (!rst_n) begin
            exp_q.delete();
            fr_tot0  = 0;
            fr_tot1  = 0;
            fr_beats = 0;
            held_v   = 1'b0;
        end else begin
            mon_sz = exp_q.size();
            check("in_ready0", bif0.in_ready, mon_sz < DEPTH);
            check("in_ready1", bif1.in_ready, mon_sz < DEPTH);
            check("out_valid0", bif0.out_valid, mon_sz != 0);
            check("out_valid1", bif1.out_valid, mon_sz != 0);
            if (held_v && mon_sz != 0) begin
                check("hold_d0", bif0.out_data, held_d0);
                check("hold_d1", bif1.out_data, held_d1);
                check("hold_cnt", bif0.out_cnt, held_c);
                check("hold_ovf0", bif0.out_ovf, held_o0);
                check("hold_ovf1", bif1.out_ovf, held_o1);
            end
            held_v  = (mon_sz != 0) && !bif0.out_ready;
            held_d0 = bif0.out_data;
            held_d1 = bif1.out_data;
            held_c  = bif0.out_cnt;
            held_o0 = bif0.out_ovf;
            held_o1 = bif1.out_ovf;
            if (mon_sz != 0 && bif0.out_ready) begin
                mon_e = exp_q.pop_front();
                cmp_head(mon_e);
            end
            if (bif0.in_valid && mon_sz < DEPTH) begin
                fr_tot0  += int'(bif0.in_data[DSIZE-1:0]) + int'(bif0.in_bit[0]);
                fr_tot1  += int'(bif0.in_data[2*DSIZE-1:DSIZE]) + int'(bif0.in_bit[1]);
                fr_beats += 1;
                if (bif0.in_last) begin
                    exp_q.push_back('{tot0: fr_tot0, tot1: fr_tot1, beats: fr_beats});
                    fr_tot0  = 0;
                    fr_tot1  = 0;
                    fr_beats = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int d0, input int d1, input int b0, input int b1, input int last);
        int n;
        n = 0;
        bif0.in_valid = 1'b1;
        bif0.in_data  = {DSIZE'(d1), DSIZE'(d0)};
        bif0.in_bit   = {1'(b1), 1'(b0)};
        bif0.in_last  = 1'(last);
        do begin
            @(negedge clock);
            n++;
        end while (!bif0.in_ready && n < 200);
        check("send_accept", bif0.in_ready, 1);
        tick();
        bif0.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{d0: 7,   d1: 0,   b0: 1, b1: 0, e0: 8,   e1: 0};
        tbl[1] = '{d0: 9,   d1: 0,   b0: 0, b1: 0, e0: 9,   e1: 0};
        tbl[2] = '{d0: 255, d1: 255, b0: 1, b1: 1, e0: 256, e1: 256};
        tbl[3] = '{d0: 0,   d1: 0,   b0: 0, b1: 0, e0: 0,   e1: 0};
        tbl[4] = '{d0: 128, d1: 3,   b0: 1, b1: 0, e0: 129, e1: 3};

        bif0.in_valid  = 1'b0;
        bif0.in_data   = '0;
        bif0.in_bit    = '0;
        bif0.in_last   = 1'b0;
        bif0.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid0", bif0.out_valid, 0);
        check("rst_out_valid1", bif1.out_valid, 0);
        check("rst_out_data", bif0.out_data, 0);
        check("rst_out_cnt", bif0.out_cnt, 0);
        check("rst_out_ovf", bif0.out_ovf, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", bif0.in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].d0, tbl[i].d1, tbl[i].b0, tbl[i].b1, 1);
            check("tbl_ch0", bif0.out_data[ASIZE-1:0], tbl[i].e0);
            check("tbl_ch1", bif0.out_data[2*ASIZE-1:ASIZE], tbl[i].e1);
            check("tbl_cnt", bif0.out_cnt, 1);
            check("tbl_ovf", bif0.out_ovf, 0);
            bif0.out_ready = 1'b1;
            tick();
            bif0.out_ready = 1'b0;
        end

        bif0.out_ready = 1'b1;
        send(10, 255, 1, 1, 0);
        check("three_not_yet", bif0.out_valid, 0);
        send(20, 255, 0, 1, 0);
        send(30, 255, 1, 1, 1);
        check("three_latency", bif0.out_valid, 1);
        check("three_ch0", bif0.out_data[ASIZE-1:0], 62);
        check("three_ch1", bif0.out_data[2*ASIZE-1:ASIZE], 768);
        check("three_cnt", bif0.out_cnt, 3);
        check("three_ovf", bif0.out_ovf, 0);
        tick();
        tick();

        bif0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(255, 0, 1, 0, (i == 3) ? 1 : 0);
        check("ovf_wrap_ch0", bif0.out_data[ASIZE-1:0], 0);
        check("ovf_wrap_flag", bif0.out_ovf, 1);
        check("ovf_sat_ch0", bif1.out_data[ASIZE-1:0], 1023);
        check("ovf_sat_flag", bif1.out_ovf, 1);
        check("ovf_sat_ch1", bif1.out_data[2*ASIZE-1:ASIZE], 0);
        check("ovf_cnt", bif0.out_cnt, 4);
        bif0.out_ready = 1'b1;
        tick();

        send(7, 0, 1, 0, 1);
        check("single_ch0", bif0.out_data[ASIZE-1:0], 8);
        check("single_cnt", bif0.out_cnt, 1);
        send(9, 0, 0, 0, 1);
        check("b2b_ch0", bif0.out_data[ASIZE-1:0], 9);
        check("b2b_cnt", bif0.out_cnt, 1);
        tick();
        tick();

        bif0.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(k, 0, 0, 0, 1);
        check("bp_full", bif0.in_ready, 0);
        bif0.in_valid = 1'b1;
        bif0.in_data  = {DSIZE'(0), DSIZE'(5)};
        bif0.in_bit   = '0;
        bif0.in_last  = 1'b1;
        repeat (3) tick();
        check("bp_still_full", bif0.in_ready, 0);
        check("bp_head", bif0.out_data[ASIZE-1:0], 1);
        bif0.out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bif0.in_ready && n < 50);
        check("bp_fifth_accept", bif0.in_ready, 1);
        tick();
        bif0.in_valid = 1'b0;
        repeat (8) tick();
        check("bp_drained", bif0.out_valid, 0);

        bif0.out_ready = 1'b0;
        send(11, 0, 0, 0, 1);
        send(12, 0, 0, 0, 1);
        send(13, 0, 0, 0, 1);
        bif0.out_ready = 1'b1;
        send(14, 0, 0, 0, 1);
        bif0.out_ready = 1'b0;
        check("pp_in_ready", bif0.in_ready, 1);
        check("pp_out_valid", bif0.out_valid, 1);
        check("pp_head", bif0.out_data[ASIZE-1:0], 12);
        send(15, 0, 0, 0, 1);
        check("pp_count_was_3", bif0.in_ready, 0);
        bif0.out_ready = 1'b1;
        repeat (8) tick();

        bif0.out_ready = 1'b0;
        send(50, 0, 0, 0, 1);
        send(100, 0, 0, 0, 0);
        send(100, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", bif0.out_valid, 0);
        check("mid_rst_in_ready", bif0.in_ready, 1);
        send(5, 0, 0, 0, 1);
        check("mid_rst_ch0", bif0.out_data[ASIZE-1:0], 5);
        check("mid_rst_cnt", bif0.out_cnt, 1);
        check("mid_rst_ovf", bif0.out_ovf, 0);
        bif0.out_ready = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 259; i++)
            send(int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(1)), int'($urandom_range(1)), (i == 258) ? 1 : 0);
        check("long_cnt_sat", bif0.out_cnt, CMAX);
        check("long_cnt_sat1", bif1.out_cnt, CMAX);
        repeat (2) tick();

        for (int i = 0; i < 800; i++) begin
            bif0.in_valid  = 1'($urandom_range(1));
            bif0.in_data   = (CH*DSIZE)'($urandom);
            bif0.in_bit    = CH'($urandom);
            bif0.in_last   = ($urandom_range(3) == 0);
            bif0.out_ready = ($urandom_range(2) != 0);
            tick();
        end
        bif0.in_valid  = 1'b0;
        bif0.out_ready = 1'b1;
        send(0, 0, 0, 0, 1);
        repeat (10) tick();
        check("final_empty", bif0.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
